// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT coefficient sequencer and its MAC.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DCT_N           = 8;
  localparam int DCT_TERMS       = DCT_N * DCT_N;
  localparam int DCT_LEVEL_SHIFT = 128;
  localparam int DCT_FRAC_BITS   = 8;
  localparam int DCT_DRAIN_CYC   = 2;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dct_mac.sv
// Level-shift / multiply / accumulate pipeline (stages 1-2) with its own valid
// pipe; acc_nxt exposes the accumulator value being written this cycle.
module dct_mac
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int COS_W       = 32,
  parameter int ACC_W       = 32,
  parameter int LEVEL_SHIFT = DCT_LEVEL_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [COS_W-1:0] cos_q,
  output logic [ACC_W-1:0] acc_nxt
);

  localparam int PROD_W = PIX_W + 1 + COS_W;

  logic [1:0]               vld;
  logic signed [PIX_W:0]    d;
  logic signed [PROD_W-1:0] prod_full;
  logic [ACC_W-1:0]         prod_q;
  logic [ACC_W-1:0]         acc;

  assign d         = $signed({1'b0, pix_data}) - $signed((PIX_W + 1)'(LEVEL_SHIFT));
  assign prod_full = PROD_W'(d) * PROD_W'($signed(cos_q));
  assign acc_nxt   = vld[1] ? acc + prod_q : acc;

  // vld[0] marks the cycle pix_data/cos_q belong to a term, vld[1] the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      prod_q <= '0;
      acc    <= '0;
    end else if (clr) begin
      vld    <= '0;
      prod_q <= '0;
      acc    <= '0;
    end else begin
      vld    <= {vld[0], issue};
      prod_q <= prod_full[ACC_W-1:0];
      acc    <= acc_nxt;
    end
  end

endmodule

// File: rtl/dct_coeff_sequencer.sv
// Walks the 64 pixel/cosine terms of an 8x8 block and returns the saturated
// DCT coefficient F(k1,k2) through a valid/ready output register.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | issuing one {n1,n2} address per cycle for 64 cycles
// DRAIN | two cycles letting the last terms clear the MAC pipeline
// DONE  | coef_valid high, result held until coef_ready
module dct_coeff_sequencer
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int COS_W       = 32,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int LEVEL_SHIFT = DCT_LEVEL_SHIFT,
  parameter int FRAC_BITS   = DCT_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_k1,
  input  logic [2:0]       req_k2,
  output logic             pix_rd_en,
  output logic [5:0]       pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic [2:0]       lut_k1,
  output logic [2:0]       lut_k2,
  output logic [2:0]       lut_n1,
  output logic [2:0]       lut_n2,
  input  logic [COS_W-1:0] cos_term,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic [OUT_W-1:0] coef_data,
  output logic [2:0]       coef_k1,
  output logic [2:0]       coef_k2,
  output logic             busy
);

  localparam logic [5:0] CNT_LAST   = 6'(DCT_TERMS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DCT_DRAIN_CYC - 1);

  state_t                  state, state_nxt;
  logic [5:0]              cnt;
  logic [1:0]              drain_cnt;
  logic [2:0]              k1_q, k2_q;
  logic [COS_W-1:0]        cos_q;
  logic [ACC_W-1:0]        acc_nxt;
  logic signed [ACC_W-1:0] acc_shr;
  logic [OUT_W-1:0]        coef_nxt;
  logic                    accept, issue, drain_last;

  assign accept     = (state == IDLE) && req_valid;
  assign issue      = (state == RUN);
  assign drain_last = (state == DRAIN) && (drain_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    pix_rd_en = 1'b0;
    pix_addr  = '0;
    lut_k1    = '0;
    lut_k2    = '0;
    lut_n1    = '0;
    lut_n2    = '0;
    coef_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        pix_rd_en = 1'b1;
        pix_addr  = cnt;
        lut_k1    = k1_q;
        lut_k2    = k2_q;
        lut_n1    = cnt[5:3];
        lut_n2    = cnt[2:0];
        if (cnt == CNT_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        lut_k1 = k1_q;
        lut_k2 = k2_q;
        if (drain_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        coef_valid = 1'b1;
        if (coef_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The final term lands in the accumulator on the same edge that enters DONE,
  // so the output register samples the accumulator's next value.
  assign acc_shr  = $signed(acc_nxt) >>> FRAC_BITS;
  assign coef_nxt = OUT_W'(saturate(64'(acc_shr), OUT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      drain_cnt <= '0;
      k1_q      <= '0;
      k2_q      <= '0;
      cos_q     <= '0;
      coef_data <= '0;
      coef_k1   <= '0;
      coef_k2   <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        k1_q <= req_k1;
        k2_q <= req_k2;
      end else if (issue) begin
        cnt <= cnt + 6'd1;
      end
      if (issue && cnt == CNT_LAST)
        drain_cnt <= DRAIN_LAST;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 2'd1;
      cos_q <= issue ? cos_term : '0;
      if (drain_last) begin
        coef_data <= coef_nxt;
        coef_k1   <= k1_q;
        coef_k2   <= k2_q;
      end
    end
  end

  dct_mac #(
    .PIX_W      (PIX_W),
    .COS_W      (COS_W),
    .ACC_W      (ACC_W),
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .issue   (issue),
    .pix_data(pix_data),
    .cos_q   (cos_q),
    .acc_nxt (acc_nxt)
  );

endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Self-checking bench: directed and randomized coefficient requests compared
// against a direct sum-of-products model of F(k1,k2).
module tb_dct_coeff_sequencer;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_k1 = '0, req_k2 = '0;
  logic        pix_rd_en;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_data = '0;
  logic [2:0]  lut_k1, lut_k2, lut_n1, lut_n2;
  logic [31:0] cos_term;
  logic        coef_valid;
  logic        coef_ready = 1'b0;
  logic [15:0] coef_data;
  logic [2:0]  coef_k1, coef_k2;
  logic        busy;

  int          tab [4096];
  logic [7:0]  pix_mem [64];
  logic [5:0]  addr_log [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dct_coeff_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_k1(req_k1), .req_k2(req_k2),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .lut_k1(lut_k1), .lut_k2(lut_k2), .lut_n1(lut_n1), .lut_n2(lut_n2),
    .cos_term(cos_term),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_k1(coef_k1), .coef_k2(coef_k2),
    .busy(busy)
  );

  // LUT bank and block buffer models
  assign cos_term = 32'(tab[{lut_k1, lut_k2, lut_n1, lut_n2}]);

  always @(posedge clk) begin
    if (pix_rd_en) begin
      pix_data <= pix_mem[pix_addr];
      addr_log.push_back(pix_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // F(k1,k2) = sat16( (sum_n trunc32((p[n]-128) * cos[k1,k2,n])) >>> 8 )
  function automatic logic [15:0] model_coef(input int k1, input int k2);
    int     acc;
    int     s;
    longint p;
    acc = 0;
    for (int n = 0; n < 64; n++) begin
      p   = longint'(int'(pix_mem[n]) - 128) * longint'(tab[k1 * 512 + k2 * 64 + n]);
      acc = acc + int'(p);
    end
    s = acc >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic fill_cos();
    real c;
    int  k1, k2, n1, n2;
    for (int i = 0; i < 4096; i++) begin
      k1 = (i >> 9) & 7; k2 = (i >> 6) & 7; n1 = (i >> 3) & 7; n2 = i & 7;
      c  = $cos((2 * n1 + 1) * k1 * PI / 16.0) * $cos((2 * n2 + 1) * k2 * PI / 16.0);
      tab[i] = $rtoi($floor(256.0 * c));
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 4096; i++) tab[i] = v;
  endtask

  task automatic fill_rand(input int span);
    for (int i = 0; i < 4096; i++) tab[i] = int'($urandom_range(2 * span, 0)) - span;
  endtask

  task automatic fill_quad(input logic [7:0] v);
    for (int n = 0; n < 64; n++) pix_mem[n] = ((n >> 3) < 4 && (n & 7) < 4) ? v : 8'd128;
  endtask

  task automatic fill_pix_rand();
    for (int n = 0; n < 64; n++) pix_mem[n] = 8'($urandom);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of T+1.
  task automatic accept_req(input logic [2:0] k1, input logic [2:0] k2);
    chk("req_ready_idle", 32'(req_ready), 1);
    addr_log.delete();
    req_valid = 1'b1; req_k1 = k1; req_k2 = k2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_k1 = 3'($urandom); req_k2 = 3'($urandom);
  endtask

  // Entered at the negedge of T+1; finishes one IDLE negedge after the handshake.
  task automatic finish_req(input logic [2:0] k1, input logic [2:0] k2,
                            input int stall, output logic [15:0] got);
    int          cyc;
    int          bad_addr;
    logic [15:0] exp;
    logic [15:0] held;
    cyc = 1;
    exp = model_coef(int'(k1), int'(k2));
    chk("busy_run", 32'(busy), 1);
    chk("req_ready_run", 32'(req_ready), 0);
    chk("lut_k1_run", 32'(lut_k1), 32'(k1));
    chk("lut_k2_run", 32'(lut_k2), 32'(k2));
    while (!coef_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 67);
    chk("coef_data", 32'(coef_data), 32'(exp));
    chk("coef_k1", 32'(coef_k1), 32'(k1));
    chk("coef_k2", 32'(coef_k2), 32'(k2));
    held = coef_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_data", 32'(coef_data), 32'(held));
      chk("hold_k", 32'({coef_k1, coef_k2}), 32'({k1, k2}));
      chk("hold_valid", 32'(coef_valid), 1);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    chk("addr_count", 32'(addr_log.size()), 64);
    bad_addr = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (int'(addr_log[i]) != i) bad_addr++;
    chk("addr_order", 32'(bad_addr), 0);
    coef_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    coef_ready = 1'b0;
    chk("idle_req_ready", 32'(req_ready), 1);
    chk("idle_coef_valid", 32'(coef_valid), 0);
    got = held;
  endtask

  initial begin
    logic [15:0] got;
    logic [2:0]  ka, kb;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_coef_valid", 32'(coef_valid), 0);
    chk("rst_pix_rd_en", 32'(pix_rd_en), 0);
    chk("rst_coef_data", 32'(coef_data), 0);
    chk("rst_lut", 32'({lut_k1, lut_k2, lut_n1, lut_n2}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // flat block
    fill_cos();
    for (int n = 0; n < 64; n++) pix_mem[n] = 8'd128;
    accept_req(3'd1, 3'd1);
    finish_req(3'd1, 3'd1, 0, got);
    chk("flat_zero", 32'(got), 0);

    // bright and dark top-left quadrant with the real cosine LUT
    fill_quad(8'd255);
    accept_req(3'd1, 3'd1);
    finish_req(3'd1, 3'd1, 1, got);
    chk("quad255", 32'(got), 32'd829);
    fill_quad(8'd0);
    accept_req(3'd1, 3'd1);
    finish_req(3'd1, 3'd1, 0, got);
    chk("quad0", 32'(got), 32'(16'hFCBC));

    // saturation with a stub LUT
    fill_const(32'h7FFF);
    for (int n = 0; n < 64; n++) pix_mem[n] = 8'd255;
    accept_req(3'd5, 3'd2);
    finish_req(3'd5, 3'd2, 0, got);
    chk("sat_pos", 32'(got), 32'h7FFF);
    for (int n = 0; n < 64; n++) pix_mem[n] = 8'd0;
    accept_req(3'd0, 3'd7);
    finish_req(3'd0, 3'd7, 0, got);
    chk("sat_neg", 32'(got), 32'h8000);

    // long downstream stall, then an immediate second request with new k
    fill_cos();
    fill_pix_rand();
    ka = 3'($urandom); kb = 3'($urandom);
    accept_req(ka, kb);
    finish_req(ka, kb, 20, got);
    accept_req(~ka, ~kb);
    finish_req(~ka, ~kb, 2, got);

    // reset during RUN cycle 30 with a request pending
    fill_rand(1000);
    fill_pix_rand();
    accept_req(3'd3, 3'd4);
    repeat (29) @(negedge clk);
    req_valid = 1'b1; req_k1 = 3'd6; req_k2 = 3'd1;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_coef_valid", 32'(coef_valid), 0);
    chk("abort_pix", 32'({pix_rd_en, pix_addr}), 0);
    chk("abort_lut", 32'({lut_k1, lut_k2, lut_n1, lut_n2}), 0);
    chk("abort_coef", 32'({coef_data, coef_k1, coef_k2}), 0);
    repeat (2) @(negedge clk);
    addr_log.delete();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    finish_req(3'd6, 3'd1, 0, got);

    // randomized blocks and LUT contents, including wide cosine values
    for (int t = 0; t < 6; t++) begin
      fill_rand((t % 2 == 0) ? 400 : 1 << 22);
      fill_pix_rand();
      ka = 3'($urandom); kb = 3'($urandom);
      accept_req(ka, kb);
      finish_req(ka, kb, int'($urandom_range(3, 0)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
